vga_vram_reader: RTL and testbench

- Display-side consumer of the VRAM read port. Generates 640x480@60 VGA timing from a 2:1 pixel-enable off `clk`.
- Drives the 17-bit VGA read address into the CPU data-RAM/VRAM block and captures the returned 6-byte word (`[5:0][7:0]`, synchronous read, 1-clk latency).
- Serializes the captured word into 8-bit grayscale pixels inside an IMG_W x IMG_H window anchored at the screen's top-left corner. Outside that window it outputs black.

---
 rtl/vga_vram_reader_if.sv | 24 ++
 rtl/vga_vram_reader.sv | 161 ++++++++++++++++
 tb/tb_vga_vram_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_reader_if.sv
// VRAM read port plus the VGA video outputs of the display reader.
// The display side (master) issues the word address and drives video;
// the memory/monitor side (slave) returns the read word and observes video.
interface vga_vram_reader_if;
    logic [5:0][7:0] vram_i;       // read word, byte [0] = lowest-addressed pixel
    logic [16:0]     A_VGA;        // word read address
    logic            hsync;        // active-low
    logic            vsync;        // active-low
    logic            blank_n;      // high in visible area
    logic [7:0]      r;
    logic [7:0]      g;
    logic [7:0]      b;
    logic            frame_start;  // one-clk pulse at start of each frame

    modport master (
        input  vram_i,
        output A_VGA, hsync, vsync, blank_n, r, g, b, frame_start
    );

    modport slave (
        output vram_i,
        input  A_VGA, hsync, vsync, blank_n, r, g, b, frame_start
    );
endinterface

// File: rtl/vga_vram_reader.sv
// VGA timing generator and VRAM word reader. Runs at a 2:1 pixel enable off
// clk, prefetches 6-pixel words from VRAM and serializes them as grayscale
// inside an IMG_W x IMG_H window at the top-left corner; black elsewhere.
module vga_vram_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256
) (
    input  logic               clk,
    input  logic               rst,
    vga_vram_reader_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [HW-1:0] H_VIS     = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS     = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_IMG     = HW'(IMG_W);
    localparam logic [VW-1:0] V_IMG     = VW'(IMG_H);
    localparam logic [2:0]    LANE_LAST = 3'd5;

    // pixel enable and raster position
    logic            r_tick;
    logic [HW-1:0]   r_hcount;
    logic [VW-1:0]   r_vcount;

    // fetch/serialize state
    logic [2:0]      r_lane;
    logic [5:0][7:0] r_buf;
    logic [16:0]     r_addr;
    logic            r_load_pend;  // word 0 is due on the tick after preload
    logic            r_primed;     // a preload has happened since reset

    // registered video outputs
    logic            r_hsync;
    logic            r_vsync;
    logic            r_blank_n;
    logic [7:0]      r_pix;
    logic            r_frame_start;

    // decoded raster conditions for the current position
    logic            w_h_last;
    logic            w_v_last;
    logic            w_in_img;
    logic            w_preload;
    logic            w_hsync_act;
    logic            w_vsync_act;
    logic            w_visible;
    logic            w_frame_top;

    assign w_h_last    = (r_hcount == H_LAST);
    assign w_v_last    = (r_vcount == V_LAST);
    assign w_in_img    = (r_hcount < H_IMG) && (r_vcount < V_IMG);
    assign w_preload   = (r_hcount == '0) && w_v_last;
    assign w_hsync_act = (r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST);
    assign w_vsync_act = (r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST);
    assign w_visible   = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign w_frame_top = (r_hcount == '0) && (r_vcount == '0);

    // 2:1 pixel enable; first advancing edge is the second clk after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tick <= 1'b0;
        else     r_tick <= ~r_tick;
    end

    // horizontal / vertical raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_tick) begin
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // sync, blanking and pixel value, one tick behind the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_pix     <= 8'd0;
        end else if (r_tick) begin
            r_hsync   <= ~w_hsync_act;
            r_vsync   <= ~w_vsync_act;
            r_blank_n <= w_visible;
            r_pix     <= w_in_img ? r_buf[r_lane] : 8'd0;
        end
    end

    // frame_start lasts exactly the clk following the (0,0) tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_frame_start <= 1'b0;
        else     r_frame_start <= r_tick && w_frame_top;
    end

    // Word fetch. The address always runs one word ahead of the buffer, so
    // the registered VRAM output for it has settled before the buffer loads.
    // The lane/address sequence continues across line ends and freezes
    // outside the window; the frame is re-aligned by the preload on the last
    // line. Before the first preload the buffer stays black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane      <= 3'd0;
            r_buf       <= '0;
            r_addr      <= 17'd0;
            r_load_pend <= 1'b0;
            r_primed    <= 1'b0;
        end else if (r_tick) begin
            if (w_preload) begin
                r_addr      <= 17'd0;
                r_lane      <= 3'd0;
                r_load_pend <= 1'b1;
            end else if (r_load_pend) begin
                r_buf       <= bus.vram_i;
                r_addr      <= r_addr + 17'd1;
                r_load_pend <= 1'b0;
                r_primed    <= 1'b1;
            end else if (w_in_img) begin
                if (r_lane == LANE_LAST) begin
                    r_lane <= 3'd0;
                    r_addr <= r_addr + 17'd1;
                    if (r_primed) r_buf <= bus.vram_i;
                end else begin
                    r_lane <= r_lane + 3'd1;
                end
            end
        end
    end

    assign bus.A_VGA       = r_addr;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.blank_n     = r_blank_n;
    assign bus.r           = r_pix;
    assign bus.g           = r_pix;
    assign bus.b           = r_pix;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_vram_reader.sv
// Bench for vga_vram_reader using a shrunken raster (24x17 total, 16x12
// visible, 8x8 image) so several frames fit in a short run. VRAM is a
// 1-clk-latency model whose word n holds bytes 6n..6n+5, so every image pixel
// shows its own linear index.
module tb_vga_vram_reader;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int IW = 8,  IH = 8;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 17
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_vram_reader_if vif();

    vga_vram_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    function automatic logic [5:0][7:0] word_of(input logic [16:0] a);
        logic [5:0][7:0] w;
        int t;
        for (int k = 0; k < 6; k++) begin
            t = int'(a) * 6 + k;
            w[k] = t[7:0];
        end
        return w;
    endfunction

    logic [5:0][7:0] vram_q = '0;
    assign vif.vram_i = vram_q;
    always @(posedge clk) vram_q <= word_of(vif.A_VGA);

    // clk edges since reset release; edge 2n+2 registers raster position n
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int fs_cnt = 0;
    always @(negedge clk) if (vif.frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance to the negedge where outputs reflect raster position (f,h,v)
    task automatic goto(input int f, input int h, input int v);
        int target;
        int guard;
        target = 2 * (f * FRAME + v * HT + h) + 2;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL goto(%0d,%0d,%0d): cyc %0d expected %0d", f, h, v, cyc, target);
        end
    endtask

    typedef struct {
        int         f, h, v;
        logic       hs, vs, bn;
        logic [7:0] pix;
        logic       fs;
        int         a;      // -1: address not checked
    } vec_t;

    vec_t tab[$];
    vec_t tab2[$];

    function automatic vec_t mk(int f, int h, int v, logic hs, logic vs, logic bn,
                                logic [7:0] pix, logic fs, int a);
        vec_t x;
        x.f = f; x.h = h; x.v = v; x.hs = hs; x.vs = vs; x.bn = bn;
        x.pix = pix; x.fs = fs; x.a = a;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        string tag;
        tag = $sformatf("f%0d_h%0d_v%0d", x.f, x.h, x.v);
        goto(x.f, x.h, x.v);
        check({tag, " hsync"},   vif.hsync,       x.hs);
        check({tag, " vsync"},   vif.vsync,       x.vs);
        check({tag, " blank_n"}, vif.blank_n,     x.bn);
        check({tag, " r"},       vif.r,           x.pix);
        check({tag, " g"},       vif.g,           x.pix);
        check({tag, " b"},       vif.b,           x.pix);
        check({tag, " fstart"},  vif.frame_start, x.fs);
        if (x.a >= 0) check({tag, " A_VGA"}, vif.A_VGA, x.a);
    endtask

    initial begin
        int lows;
        int first;

        //                f  h   v  hs vs bn pix    fs  A
        // frame 0: image window still black
        tab.push_back(mk(0, 0,  0, 1, 1, 1, 8'h00, 1, -1));
        tab.push_back(mk(0, 7,  7, 1, 1, 1, 8'h00, 0, -1));
        // frame 1: lane order, address one word ahead
        tab.push_back(mk(1, 0,  0, 1, 1, 1, 8'h00, 1,  1));
        tab.push_back(mk(1, 1,  0, 1, 1, 1, 8'h01, 0,  1));
        tab.push_back(mk(1, 5,  0, 1, 1, 1, 8'h05, 0,  2));
        tab.push_back(mk(1, 6,  0, 1, 1, 1, 8'h06, 0,  2));
        tab.push_back(mk(1, 7,  0, 1, 1, 1, 8'h07, 0,  2));
        tab.push_back(mk(1, 8,  0, 1, 1, 1, 8'h00, 0,  2));
        tab.push_back(mk(1, 15, 0, 1, 1, 1, 8'h00, 0,  2));
        tab.push_back(mk(1, 16, 0, 1, 1, 0, 8'h00, 0,  2));
        tab.push_back(mk(1, 17, 0, 1, 1, 0, 8'h00, 0,  2));
        tab.push_back(mk(1, 18, 0, 0, 1, 0, 8'h00, 0,  2));
        tab.push_back(mk(1, 20, 0, 0, 1, 0, 8'h00, 0,  2));
        tab.push_back(mk(1, 21, 0, 1, 1, 0, 8'h00, 0,  2));
        // line carry: line 1 starts mid-word
        tab.push_back(mk(1, 0,  1, 1, 1, 1, 8'h08, 0,  2));
        tab.push_back(mk(1, 3,  1, 1, 1, 1, 8'h0B, 0,  3));
        // last image pixel, then window boundary and frozen address
        tab.push_back(mk(1, 7,  7, 1, 1, 1, 8'h3F, 0, 11));
        tab.push_back(mk(1, 8,  7, 1, 1, 1, 8'h00, 0, 11));
        tab.push_back(mk(1, 0,  8, 1, 1, 1, 8'h00, 0, 11));
        tab.push_back(mk(1, 10, 11, 1, 1, 1, 8'h00, 0, 11));
        tab.push_back(mk(1, 0,  12, 1, 1, 0, 8'h00, 0, 11));
        tab.push_back(mk(1, 0,  13, 1, 0, 0, 8'h00, 0, 11));
        tab.push_back(mk(1, 0,  14, 1, 0, 0, 8'h00, 0, 11));
        tab.push_back(mk(1, 0,  15, 1, 1, 0, 8'h00, 0, 11));
        // preload on the last line
        tab.push_back(mk(1, 0,  16, 1, 1, 0, 8'h00, 0,  0));
        tab.push_back(mk(1, 1,  16, 1, 1, 0, 8'h00, 0,  1));
        tab.push_back(mk(1, 5,  16, 1, 1, 0, 8'h00, 0,  1));
        // frame 2 restarts at pixel 0
        tab.push_back(mk(2, 0,  0, 1, 1, 1, 8'h00, 1,  1));
        tab.push_back(mk(2, 5,  0, 1, 1, 1, 8'h05, 0,  2));

        // after a mid-run reset: timing restarts, window black again
        tab2.push_back(mk(0, 0,  0, 1, 1, 1, 8'h00, 1, -1));
        tab2.push_back(mk(0, 2,  0, 1, 1, 1, 8'h00, 0, -1));
        tab2.push_back(mk(0, 16, 0, 1, 1, 0, 8'h00, 0, -1));
        tab2.push_back(mk(0, 19, 0, 0, 1, 0, 8'h00, 0, -1));

        // reset state
        repeat (3) @(negedge clk);
        check("reset hsync",   vif.hsync,   1'b1);
        check("reset vsync",   vif.vsync,   1'b1);
        check("reset blank_n", vif.blank_n, 1'b0);
        check("reset rgb",     {vif.r, vif.g, vif.b}, 24'd0);
        check("reset A_VGA",   vif.A_VGA,   17'd0);
        rst = 1'b0;

        // first edge after release only toggles the pixel enable
        @(negedge clk);
        check("first edge blank_n", vif.blank_n, 1'b0);
        check("first edge fstart",  vif.frame_start, 1'b0);

        foreach (tab[i]) begin
            apply(tab[i]);
            if (tab[i].fs) begin
                @(negedge clk);
                check($sformatf("f%0d fstart width", tab[i].f), vif.frame_start, 1'b0);
            end
        end

        // hsync pulse width and position on frame 2 line 1
        lows = 0;
        first = -1;
        for (int h = 0; h < HT; h++) begin
            goto(2, h, 1);
            if (vif.hsync === 1'b0) begin
                lows++;
                if (first < 0) first = h;
            end
        end
        check("hsync low ticks", lows, HS);
        check("hsync first low", first, HA + HF);

        // vsync lines over the rest of frame 2
        lows = 0;
        first = -1;
        for (int v = 2; v < VT; v++) begin
            goto(2, 0, v);
            if (vif.vsync === 1'b0) begin
                lows++;
                if (first < 0) first = v;
            end
        end
        check("vsync low lines", lows, VS);
        check("vsync first low", first, VA + VF);
        check("frame_start pulses", fs_cnt, 3);

        // asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        check("midrst hsync",   vif.hsync,   1'b1);
        check("midrst vsync",   vif.vsync,   1'b1);
        check("midrst blank_n", vif.blank_n, 1'b0);
        check("midrst rgb",     {vif.r, vif.g, vif.b}, 24'd0);
        check("midrst A_VGA",   vif.A_VGA,   17'd0);
        check("midrst fstart",  vif.frame_start, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tab2[i]) apply(tab2[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
